// File: rtl/nand_gate_checker.sv
// Exhaustive checker for a 2-input combinational gate: drives all four input
// vectors in turn, samples the gate output after a settle time, and reports mismatches.
module nand_gate_checker #(
    parameter int         SETTLE = 2,
    parameter logic [3:0] TRUTH  = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_o,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] fail_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       gate_a_q, gate_a_d;
    logic       gate_b_q, gate_b_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_vec_q, fail_vec_d;
    logic [2:0] fail_count_q, fail_count_d;

    // NOTE: every flop updates with <= so all registers see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= 4'd0;
            gate_a_q     <= 1'b0;
            gate_b_q     <= 1'b0;
            pass_q       <= 1'b0;
            fail_vec_q   <= 4'd0;
            fail_count_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            gate_a_q     <= gate_a_d;
            gate_b_q     <= gate_b_d;
            pass_q       <= pass_d;
            fail_vec_q   <= fail_vec_d;
            fail_count_q <= fail_count_d;
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start && !abort) state_d = DRIVE;
            DRIVE:  if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
            SAMPLE: state_d = (idx_q == 2'd3) ? DONE : DRIVE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && abort) state_d = IDLE;
    end

    // Datapath next values: vector index, settle counter, results, stimulus.
    always_comb begin
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        fail_vec_d   = fail_vec_q;
        fail_count_d = fail_count_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    idx_d        = 2'd0;
                    cnt_d        = 4'd0;
                    pass_d       = 1'b0;
                    fail_vec_d   = 4'd0;
                    fail_count_d = 3'd0;
                end
            end
            DRIVE: cnt_d = cnt_q + 4'd1;
            SAMPLE: begin
                cnt_d = 4'd0;
                if (gate_o != TRUTH[idx_q]) begin
                    fail_vec_d[idx_q] = 1'b1;
                    fail_count_d      = fail_count_q + 3'd1;
                end
                if (idx_q == 2'd3) pass_d = (fail_vec_d == 4'd0);
                else               idx_d  = idx_q + 2'd1;
            end
            DONE: idx_d = 2'd0;
            default: idx_d = 2'd0;
        endcase

        // An aborted run keeps its partial mismatch record but never reports a pass.
        if (state_q != IDLE && abort) begin
            idx_d        = 2'd0;
            cnt_d        = 4'd0;
            pass_d       = 1'b0;
            fail_vec_d   = fail_vec_q;
            fail_count_d = fail_count_q;
        end

        // Stimulus follows the upcoming vector so it is stable for the whole DRIVE/SAMPLE window.
        if (state_d == DRIVE || state_d == SAMPLE) begin
            gate_a_d = idx_d[1];
            gate_b_d = idx_d[0];
        end else begin
            gate_a_d = 1'b0;
            gate_b_d = 1'b0;
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        gate_a     = gate_a_q;
        gate_b     = gate_b_q;
        pass       = pass_q;
        fail_vec   = fail_vec_q;
        fail_count = fail_count_q;
    end

endmodule

// File: doc/nand_gate_checker.md
NAND_GATE_CHECKER -- requirements
Module: nand_gate_checker

Interface
REQ-001 Parameter SETTLE, default 2, is the number of cycles each input vector is driven before sampling; legal range is 1..15.
REQ-002 Parameter TRUTH, default 4'b0111, is the expected output per vector; bit index = {A,B}; the default is the 2-input NAND truth table.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request one exhaustive check run; sampled only in IDLE.
REQ-006 abort  in  1  terminate the run in progress without a done pulse.
REQ-007 gate_o  in  1  output of the gate under test.
REQ-008 gate_a  out  1  registered A stimulus to the gate under test.
REQ-009 gate_b  out  1  registered B stimulus to the gate under test.
REQ-010 busy  out  1  high whenever the state is not IDLE.
REQ-011 done  out  1  one-cycle pulse marking run completion.
REQ-012 pass  out  1  high when all 4 vectors matched TRUTH; valid from done and held until the next accepted start.
REQ-013 fail_vec  out  4  bit i is set when vector i mismatched; held like pass.
REQ-014 fail_count  out  3  population count of fail_vec, range 0..4.

Function
REQ-015 The FSM states shall be IDLE, DRIVE, SAMPLE and DONE.
REQ-016 IDLE with start=1 shall move to DRIVE at the next edge with vector index 0 and clear fail_vec, fail_count and pass.
REQ-017 In DRIVE, {gate_a,gate_b} shall equal the index; the settle counter starts at 0 and increments each cycle; the FSM moves to SAMPLE on the edge where the counter = SETTLE-1.
REQ-018 SAMPLE shall last exactly one cycle; fail_vec[index] is set if gate_o != TRUTH[index], and fail_count increments on a mismatch.
REQ-019 SAMPLE shall move to DONE if index=3; otherwise the index increments, the FSM returns to DRIVE and the settle counter resets.
REQ-020 DONE shall last one cycle: done=1 and pass=(fail_vec==0) including the final sample; the FSM then returns to IDLE.
REQ-021 Latency: done shall be high in the cycle starting 4*(SETTLE+1) edges after the edge that accepted start (12 edges for SETTLE=2).
REQ-022 The vector order shall be 00, 01, 10, 11 with no wrap; the index never exceeds 3.
REQ-023 start shall be ignored in DRIVE, SAMPLE and DONE; a start held high through DONE begins a new run only from IDLE on the following edge.
REQ-024 abort=1 in any non-IDLE state shall force IDLE at the next edge: done stays 0, pass=0, fail_vec and fail_count retain their partial values, gate_a and gate_b go to 0.
REQ-025 If abort and start are both high in IDLE, the run shall not start.
REQ-026 gate_a and gate_b shall be 0 in IDLE and DONE.
REQ-027 gate_o shall be used unsynchronized; the gate under test is on the same clk domain.

Reset
REQ-028 rst_n=0 shall immediately force IDLE with index 0, the settle counter 0, and gate_a, gate_b, busy, done, pass, fail_vec and fail_count all 0.
REQ-029 A reset mid-run shall discard the run with no done pulse; the first start after rst_n rises shall perform a full run.

Verification (SETTLE=2, TRUTH=4'b0111)
REQ-030 Ideal NAND model on gate_a/gate_b->gate_o, start pulse -> busy for 12 cycles, then done pulse; pass=1, fail_vec=0000, fail_count=0.
REQ-031 gate_o tied 1, start -> done at edge 12, pass=0, fail_vec=1000, fail_count=1.
REQ-032 gate_o tied 0, start -> pass=0, fail_vec=0111, fail_count=3; a subsequent run with the ideal model -> fail_vec=0000, pass=1.
REQ-033 start pulsed at edge 5 of a run -> no effect: a single done at edge 12; stimulus sequence 00,01,10,11 each held 3 cycles.
REQ-034 rst_n low for 1 cycle after the vector-01 sample -> all outputs 0 asynchronously, no done; a new start after release -> a full 12-cycle run, pass=1.
REQ-035 abort at edge 7 -> IDLE at edge 8, busy=0, done never asserted, pass=0, gate_a=gate_b=0.
